// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states,
// instruction encodings and PC width.
package if_stage_pkg;

   localparam int unsigned PC_W = 16;

   localparam logic [31:0] NOP_ENC    = 32'h00000013;
   localparam logic [31:0] EBREAK_ENC = 32'h00100073;

   typedef enum logic [0:0] {
      IF_RUN  = 1'b0,
      IF_HALT = 1'b1
   } if_state_e;

   // Sequential successor address; wraps modulo 2^16.
   function automatic logic [PC_W-1:0] pc_inc4(input logic [PC_W-1:0] pc);
      return pc + 16'd4;
   endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register. Priority: reset > hold > flush > load.
// A flush writes a bubble (NOP, valid=0, zero PCs).
module if_id_reg
   import if_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            hold_i,
   input  logic            flush_i,
   input  logic [31:0]     instr_i,
   input  logic [PC_W-1:0] pc_i,
   input  logic [PC_W-1:0] pc_plus4_i,
   output logic [31:0]     instr_o,
   output logic [PC_W-1:0] pc_o,
   output logic [PC_W-1:0] pc_plus4_o,
   output logic            valid_o
);

   logic [31:0]     instr_q;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_plus4_q;
   logic            valid_q;

   // IF/ID state update
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q    <= NOP_INSTR;
         pc_q       <= 16'h0000;
         pc_plus4_q <= 16'h0000;
         valid_q    <= 1'b0;
      end else if (hold_i) begin
         instr_q    <= instr_q;
         pc_q       <= pc_q;
         pc_plus4_q <= pc_plus4_q;
         valid_q    <= valid_q;
      end else if (flush_i) begin
         instr_q    <= NOP_INSTR;
         pc_q       <= 16'h0000;
         pc_plus4_q <= 16'h0000;
         valid_q    <= 1'b0;
      end else begin
         instr_q    <= instr_i;
         pc_q       <= pc_i;
         pc_plus4_q <= pc_plus4_i;
         valid_q    <= 1'b1;
      end
   end

   assign instr_o    = instr_q;
   assign pc_o       = pc_q;
   assign pc_plus4_o = pc_plus4_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, RUN/HALT FSM and IF/ID register.
// Define IF_PERF_CNT_EN to add the saturating stall_cnt / flush_cnt outputs.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC     = 16'h0000,
   parameter logic [31:0]     NOP_INSTR    = NOP_ENC,
   parameter logic [31:0]     EBREAK_INSTR = EBREAK_ENC
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pc_write_zero,
   input  logic            IF_pipeline_write_zero,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] dest_pc,
   output logic [PC_W-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     instr_D,
   output logic [PC_W-1:0] pc_D,
   output logic [PC_W-1:0] pc_plus4_D,
   output logic            valid_D,
   output logic            halted
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]     stall_cnt,
   output logic [31:0]     flush_cnt
`endif
);

   if_state_e       state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] pc_plus4_s;
   logic            halt_trig_s;
   logic            halt_now_s;
   logic            redirect_s;
   logic            id_hold_s;
   logic            id_flush_s;

   // Next-state decode: HALT (or entering it) outranks stall, which outranks redirect
   always_comb begin
      pc_plus4_s  = pc_inc4(pc_q);
      halt_trig_s = (state_q == IF_RUN) && valid_D && (instr_D == EBREAK_INSTR)
                    && !IF_pipeline_write_zero;
      halt_now_s  = (state_q == IF_HALT) || halt_trig_s;
      redirect_s  = !halt_now_s && !pc_write_zero && branch_taken;
      id_hold_s   = !halt_now_s && IF_pipeline_write_zero;
      id_flush_s  = halt_now_s || redirect_s;
      state_d     = IF_RUN;
      pc_d        = pc_q;
      if (halt_now_s) begin
         state_d = IF_HALT;
         pc_d    = pc_q;
      end else if (pc_write_zero) begin
         pc_d    = pc_q;
      end else if (branch_taken) begin
         pc_d    = dest_pc & 16'hFFFC;
      end else begin
         pc_d    = pc_plus4_s;
      end
   end

   // PC and FSM registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         state_q <= IF_RUN;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

   assign imem_addr = pc_q;
   assign halted    = (state_q == IF_HALT);

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk        (clk),
      .reset      (reset),
      .hold_i     (id_hold_s),
      .flush_i    (id_flush_s),
      .instr_i    (imem_rdata),
      .pc_i       (pc_q),
      .pc_plus4_i (pc_plus4_s),
      .instr_o    (instr_D),
      .pc_o       (pc_D),
      .pc_plus4_o (pc_plus4_D),
      .valid_o    (valid_D)
   );

`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Saturating event counters
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if ((state_q == IF_RUN) && pc_write_zero && (stall_cnt_q != 32'hFFFFFFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (redirect_s && (flush_cnt_q != 32'hFFFFFFFF)) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural fetch model.
module tb_if_stage;

   localparam logic [15:0] RST_PC = 16'h0000;
   localparam logic [31:0] NOP    = 32'h00000013;
   localparam logic [31:0] EBRK   = 32'h00100073;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        pc_write_zero = 1'b0;
   logic        IF_pipeline_write_zero = 1'b0;
   logic        branch_taken = 1'b0;
   logic [15:0] dest_pc = 16'h0000;
   logic [15:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] instr_D;
   logic [15:0] pc_D;
   logic [15:0] pc_plus4_D;
   logic        valid_D;
   logic        halted;
`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   logic [31:0] imem [0:255];
   assign imem_rdata = imem[imem_addr[9:2]];

   always #5 clk = ~clk;

   if_stage dut (
      .clk                    (clk),
      .reset                  (reset),
      .pc_write_zero          (pc_write_zero),
      .IF_pipeline_write_zero (IF_pipeline_write_zero),
      .branch_taken           (branch_taken),
      .dest_pc                (dest_pc),
      .imem_addr              (imem_addr),
      .imem_rdata             (imem_rdata),
      .instr_D                (instr_D),
      .pc_D                   (pc_D),
      .pc_plus4_D             (pc_plus4_D),
      .valid_D                (valid_D),
      .halted                 (halted)
`ifdef IF_PERF_CNT_EN
      ,
      .stall_cnt              (stall_cnt),
      .flush_cnt              (flush_cnt)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model of the fetch stage
   logic [15:0] m_pc;
   logic [31:0] m_instr;
   logic [15:0] m_pcd;
   logic [15:0] m_pc4d;
   logic        m_valid;
   logic        m_halted;
   logic [31:0] m_sc;
   logic [31:0] m_fc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic bubble();
      m_instr = NOP;
      m_pcd   = 16'h0000;
      m_pc4d  = 16'h0000;
      m_valid = 1'b0;
   endtask

   task automatic fetch_into_id();
      m_instr = imem[m_pc[9:2]];
      m_pcd   = m_pc;
      m_pc4d  = 16'((32'(m_pc) + 32'd4) % 32'd65536);
      m_valid = 1'b1;
   endtask

   // Apply one clock edge of the rules: reset > HALT > stall > redirect > sequential
   task automatic model_update();
      if (reset) begin
         m_pc = RST_PC; bubble(); m_halted = 1'b0; m_sc = 32'd0; m_fc = 32'd0;
      end else if (m_halted || (m_valid && m_instr == EBRK && !IF_pipeline_write_zero)) begin
         if (!m_halted && pc_write_zero && m_sc != 32'hFFFFFFFF) m_sc = m_sc + 32'd1;
         m_halted = 1'b1;
         bubble();
      end else if (pc_write_zero) begin
         if (m_sc != 32'hFFFFFFFF) m_sc = m_sc + 32'd1;
         if (!IF_pipeline_write_zero) fetch_into_id();
      end else if (branch_taken) begin
         if (m_fc != 32'hFFFFFFFF) m_fc = m_fc + 32'd1;
         if (!IF_pipeline_write_zero) bubble();
         m_pc = 16'((32'(dest_pc) / 32'd4) * 32'd4);
      end else begin
         if (!IF_pipeline_write_zero) fetch_into_id();
         m_pc = 16'((32'(m_pc) + 32'd4) % 32'd65536);
      end
   endtask

   task automatic compare_all();
      chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("instr_D", instr_D, m_instr);
      chk("pc_D", 32'(pc_D), 32'(m_pcd));
      chk("pc_plus4_D", 32'(pc_plus4_D), 32'(m_pc4d));
      chk("valid_D", 32'(valid_D), 32'(m_valid));
      chk("halted", 32'(halted), 32'(m_halted));
`ifdef IF_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, m_sc);
      chk("flush_cnt", flush_cnt, m_fc);
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      compare_all();
   endtask

   task automatic drive(input logic r, input logic pwz, input logic ifwz,
                        input logic bt, input logic [15:0] d);
      reset = r; pc_write_zero = pwz; IF_pipeline_write_zero = ifwz;
      branch_taken = bt; dest_pc = d;
   endtask

   initial begin
`ifdef IF_PERF_CNT_EN
      logic [31:0] sc_before;
`endif
      m_pc = 16'h0000; bubble(); m_halted = 1'b0; m_sc = 32'd0; m_fc = 32'd0;
      for (int i = 0; i < 256; i++) imem[i] = 32'(i);
      @(negedge clk);

      // Reset, then straight-line fetch
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000); step();
      chk("rst_addr", 32'(imem_addr), 32'(RST_PC));
      chk("rst_instr", instr_D, NOP);
      chk("rst_valid", 32'(valid_D), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); step();
      chk("c1_instr", instr_D, 32'h00000000);
      chk("c1_pcd", 32'(pc_D), 32'h0);
      step();
      chk("c2_pcd", 32'(pc_D), 32'h4);
      chk("c2_pc4d", 32'(pc_plus4_D), 32'h8);
      chk("c2_valid", 32'(valid_D), 32'd1);

      // Redirect to a misaligned target
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0042); step();
      chk("br_addr", 32'(imem_addr), 32'h0040);
      chk("br_instr", instr_D, NOP);
      chk("br_valid", 32'(valid_D), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); step();
      chk("br_pcd", 32'(pc_D), 32'h0040);

      // Full stall with a branch pending
`ifdef IF_PERF_CNT_EN
      sc_before = stall_cnt;
`endif
      drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0100);
      for (int i = 0; i < 3; i++) step();
      chk("st_addr", 32'(imem_addr), 32'h0044);
      chk("st_pcd", 32'(pc_D), 32'h0040);
`ifdef IF_PERF_CNT_EN
      chk("st_cnt", stall_cnt, sc_before + 32'd3);
`endif

      // PC wrap-around
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFC); step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); step();
      chk("wr_addr", 32'(imem_addr), 32'h0000);
      chk("wr_pcd", 32'(pc_D), 32'hFFFC);
      chk("wr_pc4d", 32'(pc_plus4_D), 32'h0000);

      // EBREAK halts the stage; only reset leaves HALT
      imem[20] = EBRK;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0050); step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); step();
      chk("eb_instr", instr_D, EBRK);
      step();
      chk("hl_halted", 32'(halted), 32'd1);
      chk("hl_addr", 32'(imem_addr), 32'h0054);
      chk("hl_valid", 32'(valid_D), 32'd0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
         step();
      end
      chk("hl_hold_addr", 32'(imem_addr), 32'h0054);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0200); step();
      chk("rb_addr", 32'(imem_addr), 32'(RST_PC));
      chk("rb_halted", 32'(halted), 32'd0);
`ifdef IF_PERF_CNT_EN
      chk("rb_fcnt", flush_cnt, 32'd0);
`endif

      // Randomized traffic with occasional EBREAKs
      for (int i = 0; i < 256; i++)
         imem[i] = (($urandom % 16) == 0) ? EBRK : $urandom;
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom % 40) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
               ($urandom % 4) == 0, 16'($urandom));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
